// File: rtl/dvi_frame_sequencer.sv
// Raster timing, pixel pull and TMDS channel sequencing in the clk_pix domain.
// Optional DVI_SEQ_UF_COUNT_EN adds a per-frame saturating underflow pixel count (uf_count).
module dvi_frame_sequencer #(
  parameter int          H_RES     = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_RES     = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter logic        H_POL     = 1'b0,
  parameter logic        V_POL     = 1'b0,
  parameter logic [23:0] UF_COLOUR = 24'hFF00FF
) (
  input  logic        clk_pix,
  input  logic        rst_pix,
  input  logic        en,
  input  logic        pix_valid,
  input  logic [23:0] pix_rgb,
  output logic        pix_ready,
  output logic        de,
  output logic [7:0]  data_ch0,
  output logic [7:0]  data_ch1,
  output logic [7:0]  data_ch2,
  output logic [1:0]  ctrl_ch0,
  output logic [1:0]  ctrl_ch1,
  output logic [1:0]  ctrl_ch2,
  output logic        frame_start,
  output logic        busy,
  output logic        underflow
`ifdef DVI_SEQ_UF_COUNT_EN
  ,
  output logic [15:0] uf_count
`endif
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_RES);
  localparam logic [HW-1:0] H_SS   = HW'(H_RES + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_RES + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_RES);
  localparam logic [VW-1:0] V_SS   = VW'(V_RES + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_RES + V_FP + V_SYNC);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] sx_q, sx_d;
  logic [VW-1:0] sy_q, sy_d;
  logic          de_q, de_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [1:0]    sync_q, sync_d;
  logic          fs_q, fs_d;
  logic          busy_q, busy_d;
  logic          uf_q, uf_d;
  logic          on, act, at_end, hs_act, vs_act, uf_hit;

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    on      = (state_q != ST_IDLE);
    at_end  = (sx_q == H_LAST) && (sy_q == V_LAST);
    act     = on && (sx_q < H_ACT) && (sy_q < V_ACT);
    hs_act  = on && (sx_q >= H_SS) && (sx_q < H_SE);
    vs_act  = on && (sy_q >= V_SS) && (sy_q < V_SE);
    uf_hit  = act && !pix_valid;

    // A run stops only once the last position of the frame has been emitted.
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = at_end ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (en)          state_d = ST_RUN;
        else if (at_end) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    // IDLE parks at the last position so that starting wraps straight to (0,0).
    if (state_d != ST_IDLE) begin
      if (sx_q == H_LAST) begin
        sx_d = '0;
        sy_d = (sy_q == V_LAST) ? '0 : sy_q + VW'(1);
      end else begin
        sx_d = sx_q + HW'(1);
      end
    end

    de_d   = act;
    rgb_d  = act ? (pix_valid ? pix_rgb : UF_COLOUR) : 24'h0;
    sync_d = {vs_act ? V_POL : ~V_POL, hs_act ? H_POL : ~H_POL};
    fs_d   = on && (sx_q == '0) && (sy_q == '0);
    busy_d = on;
    uf_d   = uf_hit ? 1'b1 : (fs_d ? 1'b0 : uf_q);
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      state_q <= ST_IDLE;
      sx_q    <= H_LAST;
      sy_q    <= V_LAST;
      de_q    <= 1'b0;
      rgb_q   <= 24'h0;
      sync_q  <= {~V_POL, ~H_POL};
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      de_q    <= de_d;
      rgb_q   <= rgb_d;
      sync_q  <= sync_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      uf_q    <= uf_d;
    end
  end

`ifdef DVI_SEQ_UF_COUNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;
  logic [15:0] uf_count_q, uf_count_d;

  // Pixel (0,0) belongs to the new frame, so its underflow seeds the fresh count.
  always_comb begin
    uf_cnt_d   = uf_cnt_q;
    uf_count_d = uf_count_q;
    if (fs_d) begin
      uf_count_d = uf_cnt_q;
      uf_cnt_d   = uf_hit ? 16'd1 : 16'd0;
    end else if (uf_hit && (uf_cnt_q != 16'hFFFF)) begin
      uf_cnt_d   = uf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      uf_cnt_q   <= 16'h0;
      uf_count_q <= 16'h0;
    end else begin
      uf_cnt_q   <= uf_cnt_d;
      uf_count_q <= uf_count_d;
    end
  end

  assign uf_count = uf_count_q;
`endif

  assign pix_ready   = act;
  assign de          = de_q;
  assign data_ch2    = rgb_q[23:16];
  assign data_ch1    = rgb_q[15:8];
  assign data_ch0    = rgb_q[7:0];
  assign ctrl_ch0    = sync_q;
  assign ctrl_ch1    = 2'b00;
  assign ctrl_ch2    = 2'b00;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign underflow   = uf_q;

endmodule
